// File: rtl/alu.sv
// Registered ALU: logic, arithmetic and shift/rotate classes feeding a single
// output register. The class comes from shift/arith; the operation from op or sel.
module alu #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_1,
  input  logic [DATA_WIDTH-1:0] data_2,
  input  logic [OP_WIDTH-1:0]   op,
  input  logic [OP_WIDTH-1:0]   sel,
  input  logic                  arith,
  input  logic                  shift,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int SH_W = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] ONE  = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] ZERO = '0;

  function automatic logic [DATA_WIDTH-1:0] logic_op(
    input logic [OP_WIDTH-1:0]   code,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH-1:0] r;
    case (code)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a ^ b;
      3'b011:  r = ~(a & b);
      3'b100:  r = ~(a | b);
      3'b101:  r = ~(a ^ b);
      3'b110:  r = ~a;
      default: r = b;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] arith_op(
    input logic [OP_WIDTH-1:0]   code,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH-1:0] r;
    case (code)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = a * b;
      3'b011:  r = a + ONE;
      3'b100:  r = a - ONE;
      3'b101:  r = ZERO - a;
      3'b110:  r = ($signed(a) < $signed(b)) ? ONE : ZERO;
      default: r = (a < b) ? ONE : ZERO;
    endcase
    return r;
  endfunction

  // Rotates use a doubled operand so that n=0 naturally returns A.
  function automatic logic [DATA_WIDTH-1:0] shift_op(
    input logic [OP_WIDTH-1:0]   code,
    input logic [DATA_WIDTH-1:0] a,
    input logic [SH_W-1:0]       n
  );
    logic [DATA_WIDTH-1:0]   r;
    logic [2*DATA_WIDTH-1:0] dbl;
    dbl = '0;
    case (code)
      3'b000:  r = a << n;
      3'b001:  r = a >> n;
      3'b010:  r = DATA_WIDTH'($signed(a) >>> n);
      3'b011: begin
        dbl = {a, a} << n;
        r   = dbl[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      3'b100: begin
        dbl = {a, a} >> n;
        r   = dbl[DATA_WIDTH-1:0];
      end
      3'b101:  r = a << 1;
      3'b110:  r = a >> 1;
      default: r = a;
    endcase
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] result_p0;

  always_comb begin
    result_p0 = logic_op(op, data_1, data_2);
    if (shift)
      result_p0 = shift_op(sel, data_1, data_2[SH_W-1:0]);
    else if (arith)
      result_p0 = arith_op(op, data_1, data_2);
  end

  // Stage boundary: combinational result captured into the output register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      data_out <= '0;
    else
      data_out <= result_p0;
  end

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed cases from the block description plus randomized
// back-to-back traffic checked against an arithmetic reference model.
module tb_alu;

  localparam int W = 32;

  logic          clock;
  logic          reset;
  logic [W-1:0]  data_1;
  logic [W-1:0]  data_2;
  logic [2:0]    op;
  logic [2:0]    sel;
  logic          arith;
  logic          shift;
  logic [W-1:0]  data_out;

  int checks = 0;
  int errors = 0;

  alu #(.DATA_WIDTH(W), .OP_WIDTH(3)) dut (
    .clock    (clock),
    .reset    (reset),
    .data_1   (data_1),
    .data_2   (data_2),
    .op       (op),
    .sel      (sel),
    .arith    (arith),
    .shift    (shift),
    .data_out (data_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: word-level arithmetic on 64-bit integers, 2^32 wrap by masking.
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] o, input logic [2:0] s,
                                         input logic ar, input logic sh);
    longint unsigned ua, ub, m, p, res;
    int n;
    int sa, sb;
    ua = 64'(a);
    ub = 64'(b);
    m  = 64'hFFFF_FFFF;
    n  = int'(b % 32);
    p  = 64'd1 << n;
    sa = a;
    sb = b;
    res = 0;
    if (sh) begin
      case (s)
        3'd0: res = (ua * p) & m;
        3'd1: res = ua / p;
        3'd2: res = (ua / p) | (a[W-1] ? (m - (m >> n)) : 64'd0);
        3'd3: res = ((ua * p) & m) | (ua / (64'd1 << (32 - n)));
        3'd4: res = (ua / p) | ((ua * (64'd1 << (32 - n))) & m);
        3'd5: res = (ua * 2) & m;
        3'd6: res = ua / 2;
        default: res = ua;
      endcase
    end else if (ar) begin
      case (o)
        3'd0: res = (ua + ub) & m;
        3'd1: res = (ua + 64'h1_0000_0000 - ub) & m;
        3'd2: res = (ua * ub) & m;
        3'd3: res = (ua + 1) & m;
        3'd4: res = (ua + m) & m;
        3'd5: res = (64'h1_0000_0000 - ua) & m;
        3'd6: res = (sa < sb) ? 64'd1 : 64'd0;
        default: res = (ua < ub) ? 64'd1 : 64'd0;
      endcase
    end else begin
      case (o)
        3'd0: res = ua & ub;
        3'd1: res = ua | ub;
        3'd2: res = ua ^ ub;
        3'd3: res = m - (ua & ub);
        3'd4: res = m - (ua | ub);
        3'd5: res = m - (ua ^ ub);
        3'd6: res = m - ua;
        default: res = ub;
      endcase
    end
    return res[W-1:0];
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o,
                       input logic [2:0] s, input logic ar, input logic sh);
    @(negedge clock);
    data_1 = a; data_2 = b; op = o; sel = s; arith = ar; shift = sh;
  endtask

  // Apply one vector and compare the registered result against a fixed value.
  task automatic run_exp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] o, input logic [2:0] s, input logic ar,
                         input logic sh, input logic [W-1:0] exp);
    drive(a, b, o, s, ar, sh);
    @(posedge clock);
    #1;
    check(tag, data_out, exp);
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic [2:0]   o, s;
    logic         ar, sh;

    reset = 1'b0;
    data_1 = '0; data_2 = '0; op = '0; sel = '0; arith = 1'b0; shift = 1'b0;
    #1;
    check("reset_initial", data_out, 32'h0);
    drive(32'hDEAD_BEEF, 32'h5555_AAAA, 3'd7, 3'd0, 1'b0, 1'b0);
    @(posedge clock); #1;
    check("reset_held_edge", data_out, 32'h0);
    @(negedge clock);
    reset = 1'b1;

    run_exp("load_1234", 32'h0, 32'h1234, 3'd7, 3'd0, 1'b0, 1'b0, 32'h1234);
    #2 reset = 1'b0;
    #1;
    check("reset_async", data_out, 32'h0);
    repeat (2) begin
      @(posedge clock); #1;
      check("reset_hold", data_out, 32'h0);
    end
    @(negedge clock);
    reset = 1'b1;

    run_exp("add_wrap",   32'hFFFF_FFFF, 32'h1, 3'd0, 3'd0, 1'b1, 1'b0, 32'h0);
    run_exp("sub",        32'd5, 32'd7, 3'd1, 3'd0, 1'b1, 1'b0, 32'hFFFF_FFFE);
    run_exp("slt_signed", 32'hFFFF_FFFF, 32'h1, 3'd6, 3'd0, 1'b1, 1'b0, 32'h1);
    run_exp("slt_unsign", 32'hFFFF_FFFF, 32'h1, 3'd7, 3'd0, 1'b1, 1'b0, 32'h0);
    run_exp("neg",        32'h1, 32'h0, 3'd5, 3'd0, 1'b1, 1'b0, 32'hFFFF_FFFF);
    run_exp("mul_low",    32'h0001_0003, 32'h0001_0005, 3'd2, 3'd0, 1'b1, 1'b0, 32'h0008_000F);
    run_exp("logic_and",  32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd0, 3'd0, 1'b0, 1'b0, 32'h00F0_00F0);
    run_exp("logic_xor",  32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd2, 3'd0, 1'b0, 1'b0, 32'hFF00_FF00);
    run_exp("logic_not",  32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd6, 3'd0, 1'b0, 1'b0, 32'h0F0F_0F0F);
    run_exp("srl",        32'h8000_0001, 32'd4, 3'd0, 3'd1, 1'b0, 1'b1, 32'h0800_0000);
    run_exp("sra",        32'h8000_0001, 32'd4, 3'd0, 3'd2, 1'b0, 1'b1, 32'hF800_0000);
    run_exp("rol",        32'h8000_0001, 32'd4, 3'd0, 3'd3, 1'b0, 1'b1, 32'h0000_0018);
    run_exp("srl_hib",    32'h8000_0001, 32'h24, 3'd0, 3'd1, 1'b0, 1'b1, 32'h0800_0000);
    run_exp("sra_hib",    32'h8000_0001, 32'h24, 3'd0, 3'd2, 1'b0, 1'b1, 32'hF800_0000);
    run_exp("rol_hib",    32'h8000_0001, 32'h24, 3'd0, 3'd3, 1'b0, 1'b1, 32'h0000_0018);
    run_exp("ror",        32'h8000_0001, 32'd4, 3'd0, 3'd4, 1'b0, 1'b1, 32'h1800_0000);
    run_exp("rol_zero",   32'h8000_0001, 32'h20, 3'd0, 3'd3, 1'b0, 1'b1, 32'h8000_0001);
    run_exp("ror_zero",   32'h8000_0001, 32'h0, 3'd0, 3'd4, 1'b0, 1'b1, 32'h8000_0001);
    run_exp("priority",   32'h1, 32'd31, 3'd0, 3'd0, 1'b1, 1'b1, 32'h8000_0000);

    // Back-to-back randomized traffic: new vector every cycle.
    for (int i = 0; i < 400; i++) begin
      a  = $urandom;
      b  = (i % 4 == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
      o  = 3'($urandom_range(0, 7));
      s  = 3'($urandom_range(0, 7));
      ar = 1'($urandom_range(0, 1));
      sh = 1'($urandom_range(0, 1));
      if (i % 16 == 0) a = 32'h8000_0000 | a;
      run_exp($sformatf("rand_%0d sh%0d ar%0d op%0d sel%0d", i, sh, ar, o, s),
              a, b, o, s, ar, sh, model(a, b, o, s, ar, sh));
    end

    // Mid-stream reset discards the pending result.
    drive(32'h1234_5678, 32'h1, 3'd0, 3'd0, 1'b1, 1'b0);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    check("reset_discard", data_out, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    run_exp("after_reset", 32'h1234_5678, 32'h1, 3'd0, 3'd0, 1'b1, 1'b0, 32'h1234_5679);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
